// File: rtl/tick_meas_pkg.sv
// Shared definitions for the tick/strobe receive blocks: FSM encoding,
// default sizing and the counter saturation limit.
package tick_meas_pkg;

  // Default sizing used by tick_period_meter and sync_edge_det.
  localparam int CNT_W_DEF       = 16;
  localparam int SYNC_STAGES_DEF = 2;

  // Averaging window used when TICK_PERIOD_AVG4_EN is defined.
  localparam int AVG_DEPTH = 4;

  // Largest count held by a default-width period counter (2^CNT_W-1).
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W_DEF) - 32'd1;

  // Measurement FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_e;

  // Saturation limit for a counter of arbitrary width (w <= 31).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus registered rising-edge detector for an input that may be
// asynchronous to mclk. Latency from the input rising to edge_out is
// SYNC_STAGES+1 cycles, identical for every edge. SYNC_STAGES must be >= 2.
module sync_edge_det
  import tick_meas_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic mclk,
  input  logic rst,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  // Shift the raw input through the synchronizer and flag a 0->1 transition.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Synchronizer, edge history and edge output registers.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the synchronizer chain.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the number of mclk cycles between successive rising edges of
// tick_in and publishes the result with a one-cycle period_vld strobe.
// A missing edge for 2^CNT_W-1 cycles returns to IDLE and sets the sticky
// timeout flag.
// Optional build macro TICK_PERIOD_AVG4_EN: period_out becomes the truncated
// mean of the last four periods, valid only once four have been captured
// since reset or the last timeout.
module tick_period_meter
  import tick_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             edge_det;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic             vld_q,     vld_d;
  logic             timeout_q, timeout_d;

`ifdef TICK_PERIOD_AVG4_EN
  localparam logic [2:0] FILL_FULL = 3'(AVG_DEPTH);

  logic [CNT_W-1:0] hist_q [AVG_DEPTH];
  logic [CNT_W-1:0] hist_d [AVG_DEPTH];
  logic [CNT_W+1:0] sum_q, sum_d, sum_new;
  logic [2:0]       fill_q, fill_d;
`endif

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .mclk     (mclk),
    .rst      (rst),
    .async_in (tick_in),
    .edge_out (edge_det)
  );

  // Next-state, counter and result logic for the IDLE/MEAS machine.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    timeout_d = timeout_q;
`ifdef TICK_PERIOD_AVG4_EN
    hist_d  = hist_q;
    sum_d   = sum_q;
    fill_d  = fill_q;
    // Running sum with the oldest sample replaced by the one just measured.
    sum_new = sum_q - {2'b00, hist_q[AVG_DEPTH-1]} + {2'b00, cnt_q};
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // First edge only starts timing; nothing to publish yet.
        if (edge_det) begin
          state_d = ST_MEAS;
          cnt_d   = CNT_ONE;
        end
      end

      ST_MEAS: begin
        if (edge_det) begin
          // An edge always wins over the saturation timeout.
          cnt_d = CNT_ONE;
`ifdef TICK_PERIOD_AVG4_EN
          hist_d[0] = cnt_q;
          for (int i = 1; i < AVG_DEPTH; i++) begin
            hist_d[i] = hist_q[i-1];
          end
          sum_d = sum_new;
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 3'd1;
          end
          if (fill_d == FILL_FULL) begin
            vld_d     = 1'b1;
            period_d  = sum_new[CNT_W+1:2];
            timeout_d = 1'b0;
          end
`else
          vld_d     = 1'b1;
          period_d  = cnt_q;
          timeout_d = 1'b0;
`endif
        end else if (cnt_q == CNT_LIMIT) begin
          // Counter saturated with no edge: give up and flag it.
          state_d   = ST_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
`ifdef TICK_PERIOD_AVG4_EN
          for (int i = 0; i < AVG_DEPTH; i++) begin
            hist_d[i] = '0;
          end
          sum_d  = '0;
          fill_d = 3'd0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter and published result registers.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      vld_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      vld_q     <= vld_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef TICK_PERIOD_AVG4_EN
  // Averaging history, running sum and fill counter.
  // NOTE: the history array is reset explicitly because the running sum
  // subtracts the oldest entry and relies on it starting at zero.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      sum_q  <= '0;
      fill_q <= 3'd0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end
`endif

  assign period_out = period_q;
  assign period_vld = vld_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q == ST_MEAS);

endmodule

// File: tb/tb_tick_period_meter.sv
// Self-checking bench for tick_period_meter (CNT_W=8, SYNC_STAGES=2).
// The reference model works on sampled edge timestamps: a period is the
// difference in cycle numbers between consecutive rising edges, delayed by
// the fixed synchronizer latency. Honours TICK_PERIOD_AVG4_EN if defined.
module tb_tick_period_meter;

  localparam int CW    = 8;
  localparam int SS    = 2;
  localparam int LAT   = SS + 1;
  localparam int LIMIT = (1 << CW) - 1;

  logic          mclk = 1'b0;
  logic          rst  = 1'b0;
  logic          tick_in = 1'b0;
  logic [CW-1:0] period_out;
  logic          period_vld;
  logic          timeout;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  bit rise_q[$];
  bit prev_t;
  bit m_active;
  int m_last;
  int cyc;
  bit m_vld;
  int m_period;
  bit m_timeout;
  int hist[$];

  always #5 mclk = ~mclk;

  tick_period_meter #(
    .CNT_W       (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .mclk       (mclk),
    .rst        (rst),
    .tick_in    (tick_in),
    .period_out (period_out),
    .period_vld (period_vld),
    .timeout    (timeout),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s at model cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    rise_q.delete();
    for (int i = 0; i < LAT; i++) rise_q.push_back(1'b0);
    prev_t    = 1'b0;
    m_active  = 1'b0;
    m_last    = 0;
    cyc       = 0;
    m_vld     = 1'b0;
    m_period  = 0;
    m_timeout = 1'b0;
    hist.delete();
  endtask

  // One mclk edge of the model; t is the tick_in value sampled on that edge.
  task automatic model_step(input bit t);
    bit eff;
    int diff;
    int s;
    cyc++;
    eff = rise_q.pop_front();
    rise_q.push_back(t & ~prev_t);
    prev_t = t;
    m_vld  = 1'b0;
    if (eff) begin
      if (m_active) begin
        diff = cyc - m_last;
`ifdef TICK_PERIOD_AVG4_EN
        hist.push_back(diff);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
          s = 0;
          foreach (hist[i]) s += hist[i];
          m_vld    = 1'b1;
          m_period = s / 4;
        end
`else
        s        = 0;
        m_vld    = 1'b1;
        m_period = diff + s;
`endif
        if (m_vld) m_timeout = 1'b0;
      end
      m_active = 1'b1;
      m_last   = cyc;
    end else if (m_active && (cyc - m_last) == LIMIT) begin
      m_active  = 1'b0;
      m_timeout = 1'b1;
      hist.delete();
    end
  endtask

  task automatic check_all();
    check("period_vld", 32'(period_vld), 32'(m_vld));
    check("period_out", 32'(period_out), 32'(m_period));
    check("timeout",    32'(timeout),    32'(m_timeout));
    check("busy",       32'(busy),       32'(m_active));
  endtask

  // Drive tick_in for one cycle, advance the model, compare on the falling edge.
  task automatic cycle(input bit t);
    tick_in = t;
    @(posedge mclk);
    if (rst) model_step(t);
    else     model_reset();
    @(negedge mclk);
    check_all();
  endtask

  task automatic pulse_train(input int period, input int n, input int width);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < period; i++) cycle(i < width);
    end
  endtask

  initial begin
    int per;
    int cnt;
    int wid;

    model_reset();
    // Reset values while rst is held low.
    repeat (3) cycle(1'b0);
    rst = 1'b1;

    // Pulse every 10 cycles.
    pulse_train(10, 6, 1);
    repeat (LAT + 1) cycle(1'b0);
`ifndef TICK_PERIOD_AVG4_EN
    check("p10_value", 32'(period_out), 32'd10);
`endif
    check("p10_busy", 32'(busy), 32'd1);

    // Toggle every cycle: minimum period of 2.
    pulse_train(2, 20, 1);
`ifndef TICK_PERIOD_AVG4_EN
    check("toggle_value", 32'(period_out), 32'd2);
`endif

    // One edge then silence: timeout, then two edges 7 apart.
    cycle(1'b1);
    repeat (300) cycle(1'b0);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    pulse_train(7, 2, 1);
    repeat (LAT + 2) cycle(1'b0);
`ifndef TICK_PERIOD_AVG4_EN
    check("to_p7_value", 32'(period_out), 32'd7);
    check("to_p7_clear", 32'(timeout), 32'd0);
`endif

    // Second edge exactly 2^CW-1 cycles after the first: edge wins.
    cycle(1'b1);
    repeat (LIMIT - 1) cycle(1'b0);
    cycle(1'b1);
    repeat (LAT + 1) cycle(1'b0);
`ifndef TICK_PERIOD_AVG4_EN
    check("max_value", 32'(period_out), 32'(LIMIT));
    check("max_no_to", 32'(timeout), 32'd0);
`endif

    // Reset in the middle of a 10-cycle stream.
    pulse_train(10, 3, 1);
    cycle(1'b1);
    repeat (LAT + 4) cycle(1'b0);
    rst = 1'b0;
    #1;
    check("rst_vld",     32'(period_vld), 32'd0);
    check("rst_period",  32'(period_out), 32'd0);
    check("rst_timeout", 32'(timeout),    32'd0);
    check("rst_busy",    32'(busy),       32'd0);
    cycle(1'b0);
    rst = 1'b1;
    pulse_train(10, 6, 1);

    // Periods 8,12,8,12,9 (averages to 10 then 41/4=10 in AVG4 mode).
    pulse_train(8, 1, 1);
    pulse_train(12, 1, 1);
    pulse_train(8, 1, 1);
    pulse_train(12, 1, 1);
    pulse_train(9, 1, 1);
    cycle(1'b1);
    repeat (LAT + 1) cycle(1'b0);
`ifdef TICK_PERIOD_AVG4_EN
    check("avg_value", 32'(period_out), 32'd10);
`endif

    // Randomized segments, including occasional timeouts.
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 9) == 0) per = $urandom_range(250, 300);
      else                           per = $urandom_range(2, 30);
      cnt = $urandom_range(1, 6);
      wid = $urandom_range(1, per - 1);
      pulse_train(per, cnt, wid);
    end
    repeat (LIMIT + 10) cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
